// File: rtl/panel_pkg.sv
// Shared types and constants for the panel character-select path.
package panel_pkg;

  // Width of the debounce stability counter; DEBOUNCE_CYCLES-1 must fit in it.
  localparam int CNT_W = 20;

  // Debounce FSM states. The two WAIT_* states are the "level changed, not yet trusted" phases.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/btn_debouncer.sv
// Push-button conditioning: 2-flop synchronizer followed by a 4-state debounce FSM.
// Emits a one-cycle registered press_pulse when a press has been stable for
// DEBOUNCE_CYCLES consecutive synchronized samples. Releases are debounced the
// same way but produce no pulse.
module btn_debouncer
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_in,
  output logic            press_pulse,
  output debounce_state_t dbg_state
);

  // The counter clears to 0 on entry to a WAIT state (the first stable sample)
  // and the transition fires on the sample that brings it to DEBOUNCE_CYCLES-1,
  // so exactly DEBOUNCE_CYCLES stable samples are seen before the level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic            r_sync_0;
  logic            r_sync_1;
  logic            w_synced;
  debounce_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_press_pulse;

  assign w_synced = r_sync_1;

  // Synchronizer and debounce FSM; pulse and state are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_0      <= 1'b0;
      r_sync_1      <= 1'b0;
      r_state       <= RELEASED;
      r_cnt         <= '0;
      r_press_pulse <= 1'b0;
    end else begin
      r_sync_0      <= btn_in;
      r_sync_1      <= r_sync_0;
      r_press_pulse <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_synced) begin
            r_state <= WAIT_PRESS;
            r_cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!w_synced) begin
            r_state <= RELEASED;
          end else if (r_cnt >= CNT_PRELAST) begin
            // Counter reaches its ceiling and holds there; never wraps.
            r_state       <= PRESSED;
            r_cnt         <= CNT_LAST;
            r_press_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_synced) begin
            r_state <= WAIT_RELEASE;
            r_cnt   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (w_synced) begin
            r_state <= PRESSED;
          end else if (r_cnt >= CNT_PRELAST) begin
            r_state <= RELEASED;
            r_cnt   <= CNT_LAST;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign press_pulse = r_press_pulse;
  assign dbg_state   = r_state;

endmodule

// File: rtl/char_select.sv
// Character select for the plotter. A debounced button press arms a pending
// flag; the character flips only on the next vsync leading edge so the change
// never tears a frame. Several presses within one frame collapse to one flip.
module char_select
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 250000,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_in,
  input  logic            vsync,
  output logic            char,
  output logic            press_pulse,
  output logic            pending,
  output debounce_state_t dbg_state
);

  // press_pulse is a single-cycle strobe with no back-pressure: whoever sees it
  // high on a rising edge must take it then, there is no ready/hold.

  logic w_press_pulse;
  logic w_vsync_act;
  logic w_frame_edge;
  logic r_vsync_act_prev;
  logic r_char;
  logic r_pending;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .press_pulse (w_press_pulse),
    .dbg_state   (dbg_state)
  );

  // Normalise vsync to "1 = active" so the edge detector is polarity-free.
  assign w_vsync_act  = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign w_frame_edge = w_vsync_act & ~r_vsync_act_prev;

  // Previous vsync level; reset to inactive so a vsync already active right
  // after reset is treated as a boundary on the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_act_prev <= 1'b0;
    end else begin
      r_vsync_act_prev <= w_vsync_act;
    end
  end

  // Pending/char update: a press arriving on the boundary cycle is applied
  // immediately instead of waiting a whole extra frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_char    <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_frame_edge) begin
      if (r_pending || w_press_pulse) begin
        r_char <= ~r_char;
      end
      r_pending <= 1'b0;
    end else if (w_press_pulse) begin
      r_pending <= 1'b1;
    end
  end

  assign char        = r_char;
  assign pending     = r_pending;
  assign press_pulse = w_press_pulse;

endmodule

// File: tb/tb_char_select.sv
// Directed bench for char_select with DEBOUNCE_CYCLES=4 and active-low vsync.
module tb_char_select;
  import panel_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_in;
  logic            vsync;
  logic            char;
  logic            press_pulse;
  logic            pending;
  debounce_state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  char_select #(
    .DEBOUNCE_CYCLES  (4),
    .VSYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .vsync       (vsync),
    .char        (char),
    .press_pulse (press_pulse),
    .pending     (pending),
    .dbg_state   (dbg_state)
  );

  // Advance n rising edges; outputs are observed 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run n cycles and return how many press pulses were seen.
  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (press_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_in = 1'b0; vsync = 1'b1;
    tick(3);
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL reset_char: got %b want 0", char); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", pending); end
    n_cmp++; if (press_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", press_pulse); end
    n_cmp++; if (dbg_state !== RELEASED) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, RELEASED); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_press;
    int cnt;
    int first;
    int rel;
    cnt = 0; first = 0;
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (press_pulse === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL clean_pulse_count: got %0d want 1", cnt); end
    n_cmp++; if (first < 5 || first > 7) begin n_bad++; $display("FAIL clean_pulse_latency: got %0d want 5..7", first); end
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL clean_pending: got %b want 1", pending); end
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL clean_char: got %b want 0", char); end
    btn_in = 1'b0;
    run_count(12, rel);
    n_cmp++; if (rel !== 0) begin n_bad++; $display("FAIL release_no_pulse: got %0d want 0", rel); end
    n_cmp++; if (dbg_state !== RELEASED) begin n_bad++; $display("FAIL release_state: got %0d want %0d", dbg_state, RELEASED); end
  endtask

  task automatic test_bounce;
    int bounce_cnt;
    int hold_cnt;
    int p;
    bounce_cnt = 0;
    for (int seg = 0; seg < 6; seg++) begin
      btn_in = (seg % 2 == 0);
      run_count(2, p);
      bounce_cnt += p;
    end
    btn_in = 1'b1;
    run_count(20, hold_cnt);
    n_cmp++; if (bounce_cnt !== 0) begin n_bad++; $display("FAIL bounce_no_pulse: got %0d want 0", bounce_cnt); end
    n_cmp++; if (hold_cnt !== 1) begin n_bad++; $display("FAIL bounce_one_pulse: got %0d want 1", hold_cnt); end
    btn_in = 1'b0;
    tick(12);
  endtask

  task automatic test_frame_apply;
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL frame_pre_pending: got %b want 1", pending); end
    vsync = 1'b0;
    tick(1);
    n_cmp++; if (char !== 1'b1) begin n_bad++; $display("FAIL frame_char_toggle: got %b want 1", char); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL frame_pending_clear: got %b want 0", pending); end
    tick(10);
    n_cmp++; if (char !== 1'b1) begin n_bad++; $display("FAIL frame_vsync_held: got %b want 1", char); end
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(1);
    n_cmp++; if (char !== 1'b1) begin n_bad++; $display("FAIL frame_no_pending_hold: got %b want 1", char); end
    vsync = 1'b1;
    tick(2);
  endtask

  task automatic test_coincidence;
    int waited;
    waited = 0;
    btn_in = 1'b1;
    while (press_pulse !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    n_cmp++; if (press_pulse !== 1'b1) begin n_bad++; $display("FAIL coin_pulse_timeout: got %b want 1", press_pulse); end
    vsync = 1'b0;
    tick(1);
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL coin_char_toggle: got %b want 0", char); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL coin_pending: got %b want 0", pending); end
    tick(3);
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL coin_pending_later: got %b want 0", pending); end
    btn_in = 1'b0; vsync = 1'b1;
    tick(12);
  endtask

  task automatic test_double_press;
    int total;
    int p;
    total = 0;
    btn_in = 1'b1; run_count(10, p); total += p;
    btn_in = 1'b0; run_count(20, p); total += p;
    btn_in = 1'b1; run_count(10, p); total += p;
    btn_in = 1'b0; run_count(15, p); total += p;
    n_cmp++; if (total !== 2) begin n_bad++; $display("FAIL double_pulse_count: got %0d want 2", total); end
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL double_pending: got %b want 1", pending); end
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL double_char_before: got %b want 0", char); end
    vsync = 1'b0;
    tick(1);
    n_cmp++; if (char !== 1'b1) begin n_bad++; $display("FAIL double_char_once: got %b want 1", char); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL double_pending_clear: got %b want 0", pending); end
    vsync = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid;
    int p;
    btn_in = 1'b1; tick(10);
    btn_in = 1'b0; tick(12);
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_pending: got %b want 1", pending); end
    btn_in = 1'b1; tick(3);
    rst = 1'b1; btn_in = 1'b0;
    tick(1);
    rst = 1'b0;
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rmid_pending: got %b want 0", pending); end
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL rmid_char: got %b want 0", char); end
    n_cmp++; if (dbg_state !== RELEASED) begin n_bad++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, RELEASED); end
    vsync = 1'b0;
    tick(1);
    n_cmp++; if (char !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_char: got %b want 0", char); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_pending: got %b want 0", pending); end
    vsync = 1'b1;
    run_count(10, p);
    n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL rmid_no_pulse: got %0d want 0", p); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_frame_apply();
    test_coincidence();
    test_double_press();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_select.md
CHAR_SELECT -- requirements
Module: char_select

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized samples needed to accept a button level change; legal range 2..2^20-1.
REQ-002 Parameter VSYNC_ACTIVE_LOW, default 1: 1 means vsync asserts low; 0 means vsync asserts high.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 vsync  input  1  frame sync from the display timing stage, same clock domain.
REQ-007 char  output  1  registered character select driven to the plotter; changes only at a frame boundary.
REQ-008 press_pulse  output  1  one-cycle pulse per accepted press.
REQ-009 pending  output  1  high while an accepted press is waiting for the next frame boundary.

Function
REQ-010 btn_in shall pass through a 2-flop synchronizer before any other use; synchronizer latency = 2 cycles.
REQ-011 The debouncer shall be a 4-state FSM: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-012 RELEASED: synced=1 -> WAIT_PRESS, counter cleared to 0.
REQ-013 WAIT_PRESS: synced=0 -> RELEASED; otherwise counter increments; when counter reaches DEBOUNCE_CYCLES-1 with synced=1 -> PRESSED.
REQ-014 The RELEASED-to-PRESSED transition (WAIT_PRESS -> PRESSED) shall assert press_pulse for exactly that one cycle.
REQ-015 PRESSED: synced=0 -> WAIT_RELEASE, counter cleared to 0.
REQ-016 WAIT_RELEASE: synced=1 -> PRESSED; otherwise the counter counts as in WAIT_PRESS; at DEBOUNCE_CYCLES-1 -> RELEASED; no pulse on release.
REQ-017 The counter shall be 20 bits, unsigned, and shall never wrap; it shall hold at DEBOUNCE_CYCLES-1.
REQ-018 Frame boundary = the single cycle on which vsync goes from inactive (previous cycle, registered) to active (current cycle), with polarity set by VSYNC_ACTIVE_LOW.
REQ-019 press_pulse=1 shall set pending on the next edge.
REQ-020 On a frame boundary with pending=1: char <= ~char and pending <= 0 on the same edge.
REQ-021 On a frame boundary with pending=0, char shall hold.
REQ-022 press_pulse and a frame boundary in the same cycle: char toggles on that edge and pending ends at 0. Net effect: the press is consumed immediately.
REQ-023 Multiple presses before one frame boundary: pending saturates at 1, and char toggles exactly once.
REQ-024 vsync held active indefinitely: no further boundaries occur, and char holds.
REQ-025 press_pulse latency from a clean btn_in rise = 2 + DEBOUNCE_CYCLES cycles, plus or minus 1.

Reset
REQ-026 While rst=1: FSM=RELEASED, counter=0, synchronizer flops=0, previous-vsync register=inactive level, char=0, pending=0, press_pulse=0.
REQ-027 rst asserted mid-debounce or with pending=1 shall discard all progress; no toggle follows the release of rst.
REQ-028 The first frame boundary evaluation shall occur on the first cycle after rst deasserts.

Structure
REQ-029 Package panel_pkg shall hold the debounce state enum (RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE) and the 20-bit counter width constant.
REQ-030 The synchronizer and debounce FSM shall live in sub-module btn_debouncer (outputs press_pulse).
REQ-031 char_select shall contain btn_debouncer, the vsync edge detect, and the pending/char registers.
REQ-032 char_select output char shall connect directly to the char input of the display top level.

Verification (DEBOUNCE_CYCLES=4, VSYNC_ACTIVE_LOW=1)
REQ-033 Clean press: btn_in 0->1 held 20 cycles, no frame boundary -> one press_pulse 6+/-1 cycles after the rise, then pending=1 and char=0.
REQ-034 Bounce: btn_in toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one press_pulse; none during the bounce.
REQ-035 Frame apply: pending=1, then vsync 1->0 -> char 0->1 and pending 1->0 on that edge; a later boundary with pending=0 leaves char=1.
REQ-036 Coincidence: press_pulse in the same cycle as the vsync falling edge -> char toggles on that edge and pending stays 0.
REQ-037 Double press: two clean presses 30 cycles apart, boundary afterwards -> char toggles once (0->1).
REQ-038 Reset mid-operation: pending=1, rst pulsed 1 cycle, then vsync falling edge -> char=0 and pending=0.
